key_debounce: RTL and testbench
===============================

# key_debounce

Debounce and edge-detect stage that sits directly upstream of the Nios key PIO input port. It synchronises the raw, bouncy, active-low push-button pins into the system clock domain and filters out contact bounce. It presents a clean level to the PIO `in_port` and also produces one-cycle press/release pulses for optional interrupt or capture logic. Polarity is preserved (0 = pressed), so existing software reading the PIO is unaffected.

## Interface
- `WIDTH`, 4: number of keys.
- `DEBOUNCE_CYCLES`, 1_000_000: stable cycles required before a change is accepted (20 ms at 50 MHz); legal range ≥ 2.
- `CNT_W`, 20: counter width; must satisfy 2^CNT_W ≥ DEBOUNCE_CYCLES.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `key_in` in WIDTH: raw button pins, asynchronous, active-low.
- `key_out` out WIDTH: debounced level, active-low; feeds PIO `in_port`.
- `press_pulse` out WIDTH: one-cycle high when the debounced key goes 1→0.
- `release_pulse` out WIDTH: one-cycle high when the debounced key goes 0→1.

## Operation
- Each key is processed independently, with no interaction between bits.
- **Synchroniser:** 2-flop chain per bit. The stage-2 output is `sync`.
- **Per-key FSM,** states `STABLE` and `SETTLE`, plus per-key counter `cnt` (CNT_W bits):
  - `STABLE`:
    - If `sync != key_out`: go to `SETTLE`, `cnt <= 0`.
    - Otherwise hold, `cnt <= 0`.
  - `SETTLE`:
    - If `sync == key_out` (bounce returned): go to `STABLE`, `cnt <= 0`, no output change.
    - Else if `cnt == DEBOUNCE_CYCLES-1`: `key_out <= sync`, fire the matching pulse, go to `STABLE`, `cnt <= 0`.
    - Else `cnt <= cnt + 1`.
- **Pulses:** registered, high for exactly the one cycle after `key_out` updates. `press_pulse` fires when the new value is 0; `release_pulse` fires when it is 1. The two pulses are never high together on the same bit.
- **Counter:** `cnt` never exceeds `DEBOUNCE_CYCLES-1`, so it cannot wrap.
- **Reset values** (all outputs released/idle):
  - Synchroniser flops: all 1.
  - `key_out`: all 1.
  - Pulses: 0.
  - FSM: `STABLE`.
  - `cnt`: 0.
- **Reset mid-`SETTLE`:** the pending change is discarded. After release, a still-pressed key re-qualifies from scratch with full latency.
- **Simultaneous changes** on several keys are handled in parallel; pulses may assert on several bits in the same cycle.

## Timing
- Sample point: `key_in` changes before edge 0 and then stays stable.
  - `sync` updates after edge 2.
  - FSM enters `SETTLE` at edge 3.
  - `key_out` and the pulse update at edge `DEBOUNCE_CYCLES+3`.
  - Total latency: `DEBOUNCE_CYCLES+3` cycles.
- A glitch on `sync` shorter than `DEBOUNCE_CYCLES+1` cycles produces no output change.
- Any return to the old level during `SETTLE` restarts qualification in full.
- Pulse width is exactly 1 cycle. `key_out` is registered, with no combinational path from `key_in`.

## Structure
- Package `key_debounce_pkg` holds:
  - The state enum `kd_state_t` {`KD_STABLE`, `KD_SETTLE`}.
  - The default constants `KD_DEBOUNCE_CYCLES` and `KD_CNT_W`.
- Sub-module `key_debounce_chan` contains the 1-bit synchroniser, FSM, counter and pulse flops. It is instantiated `WIDTH` times via generate. The top level only wires the buses.

## Test plan
Bench parameters: `WIDTH=4`, `DEBOUNCE_CYCLES=8`.
1. **Reset:** assert `reset` with `key_in=4'b0000` → `key_out=4'b1111` and pulses `0` while reset is asserted.
2. **Clean press:** `key_in[0]` 1→0 before edge 0 and held → `key_out[0]` goes 0 after edge 11, `press_pulse=4'b0001` for exactly 1 cycle, other bits unchanged.
3. **Bounce:** `key_in[1]` low for 5 cycles, high for 2, then low and held → no change during the bounce; `key_out[1]` falls 11 cycles after the final falling edge; exactly one `press_pulse[1]`.
4. **Release:** from pressed, `key_in[0]` 0→1 and held → `key_out[0]` goes 1 after 11 cycles, `release_pulse=4'b0001` for 1 cycle, no `press_pulse`.
5. **Simultaneous:** `key_in` 1111→0000 in one cycle → all `key_out` bits fall on the same edge, `press_pulse=4'b1111` for 1 cycle.
6. **Reset mid-SETTLE:** pulse `reset` 5 cycles after `key_in[2]` falls, keep the key low → `key_out[2]` stays 1 through reset, then falls 11 cycles after reset deasserts.

Source files
------------

// File: rtl/key_debounce_pkg.sv
// Shared types and default constants for the key debouncer.
package key_debounce_pkg;

  typedef enum logic {
    KD_STABLE,
    KD_SETTLE
  } kd_state_t;

  // 20 ms of stability at 50 MHz
  localparam int KD_DEBOUNCE_CYCLES = 1_000_000;
  localparam int KD_CNT_W           = 20;

endpackage

// File: rtl/key_debounce_chan.sv
// Single-key channel: 2-flop synchroniser, STABLE/SETTLE qualifier and press/release pulse flops.
module key_debounce_chan
  import key_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = KD_DEBOUNCE_CYCLES,
  parameter int CNT_W           = KD_CNT_W
) (
  input  logic clk,
  input  logic reset,
  input  logic key_in,
  output logic key_out,
  output logic press_pulse,
  output logic release_pulse
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_p0;
  logic             sync_p1;
  kd_state_t        state;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_p0       <= 1'b1;
      sync_p1       <= 1'b1;
      key_out       <= 1'b1;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      state         <= KD_STABLE;
      cnt           <= '0;
    end else begin
      // synchroniser stages; sync_p1 is the qualified-domain copy of the pin
      sync_p0       <= key_in;
      sync_p1       <= sync_p0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;

      case (state)
        KD_STABLE: begin
          cnt <= '0;
          if (sync_p1 != key_out) state <= KD_SETTLE;
        end
        KD_SETTLE: begin
          if (sync_p1 == key_out) begin
            // bounced back before qualifying: discard and start over
            state <= KD_STABLE;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            key_out       <= sync_p1;
            press_pulse   <= ~sync_p1;
            release_pulse <= sync_p1;
            state         <= KD_STABLE;
            cnt           <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= KD_STABLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/key_debounce.sv
// Debounce and edge-detect stage for active-low push buttons ahead of the key PIO.
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = KD_DEBOUNCE_CYCLES,
  parameter int CNT_W           = KD_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] key_in,
  output logic [WIDTH-1:0] key_out,
  output logic [WIDTH-1:0] press_pulse,
  output logic [WIDTH-1:0] release_pulse
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    key_debounce_chan #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_chan (
      .clk          (clk),
      .reset        (reset),
      .key_in       (key_in[i]),
      .key_out      (key_out[i]),
      .press_pulse  (press_pulse[i]),
      .release_pulse(release_pulse[i])
    );
  end

endmodule

// File: tb/tb_key_debounce.sv
// Scoreboard bench for key_debounce: a window model predicts outputs per edge, the monitor compares.
module tb_key_debounce;

  localparam int W  = 4;
  localparam int D  = 8;
  localparam int CW = 4;
  localparam int HL = D + 3;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] key_in;
  logic [W-1:0] key_out;
  logic [W-1:0] press_pulse;
  logic [W-1:0] release_pulse;

  always #5 clk = ~clk;

  key_debounce #(
    .WIDTH          (W),
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (CW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .key_in       (key_in),
    .key_out      (key_out),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse)
  );

  typedef struct packed {
    logic [W-1:0] ko;
    logic [W-1:0] pp;
    logic [W-1:0] rp;
  } exp_t;

  exp_t         sb_q[$];
  exp_t         cur;
  logic [W-1:0] hist[HL];
  logic [W-1:0] m_ko;
  logic [W-1:0] m_pp;
  logic [W-1:0] m_rp;
  logic         settled;
  int           checks = 0;
  int           errors = 0;
  int           press_cnt[W];
  int           rel_cnt[W];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // A key flips once the pin has sat at the opposite level for the D+1 samples
  // that reach the qualifier (samples 2..HL-1 ago, after the 2-flop delay).
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < HL; i++) hist[i] = '1;
      m_ko = '1;
      m_pp = '0;
      m_rp = '0;
    end else begin
      for (int i = HL - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = key_in;
      m_pp = '0;
      m_rp = '0;
      for (int b = 0; b < W; b++) begin
        settled = 1'b1;
        for (int i = 2; i < HL; i++) if (hist[i][b] == m_ko[b]) settled = 1'b0;
        if (settled) begin
          m_ko[b] = ~m_ko[b];
          if (m_ko[b]) m_rp[b] = 1'b1;
          else         m_pp[b] = 1'b1;
        end
      end
    end
    sb_q.push_back('{ko: m_ko, pp: m_pp, rp: m_rp});
  end

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      cur = sb_q.pop_front();
      chk("key_out", 32'(key_out), 32'(cur.ko));
      chk("press_pulse", 32'(press_pulse), 32'(cur.pp));
      chk("release_pulse", 32'(release_pulse), 32'(cur.rp));
      chk("pulse_excl", 32'(press_pulse & release_pulse), 32'(0));
      for (int b = 0; b < W; b++) begin
        press_cnt[b] += int'(press_pulse[b]);
        rel_cnt[b]   += int'(release_pulse[b]);
      end
    end
  end

  task automatic drive(input logic [W-1:0] v);
    @(negedge clk);
    #1 key_in = v;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic latency(input string tag, input int idx, input logic val, input int exp_lat);
    int  n;
    bit  hit;
    n   = 0;
    hit = 1'b0;
    while (!hit && n < 50) begin
      @(negedge clk);
      n++;
      if (key_out[idx] === val) hit = 1'b1;
    end
    chk(tag, hit ? 32'(n) : 32'hFFFF_FFFF, 32'(exp_lat));
  endtask

  initial begin
    for (int b = 0; b < W; b++) begin
      press_cnt[b] = 0;
      rel_cnt[b]   = 0;
    end
    reset  = 1'b1;
    key_in = '0;
    idle(3);
    chk("reset_key_out", 32'(key_out), 32'hF);
    chk("reset_press", 32'(press_pulse), 32'h0);
    chk("reset_release", 32'(release_pulse), 32'h0);
    @(negedge clk);
    #1 begin
      key_in = '1;
      reset  = 1'b0;
    end
    idle(14);

    // clean press on key 0
    drive(4'b1110);
    latency("press0_lat", 0, 1'b0, 11);
    idle(3);

    // key 1 bounces: 5 low, 2 high, then held low
    drive(4'b1100);
    idle(4);
    drive(4'b1110);
    idle(1);
    drive(4'b1100);
    latency("press1_lat", 1, 1'b0, 11);
    idle(3);

    // release key 0
    drive(4'b1101);
    latency("release0_lat", 0, 1'b1, 11);
    idle(3);

    // all keys pressed together
    drive(4'b1111);
    idle(15);
    drive(4'b0000);
    latency("all_press_lat", 0, 1'b0, 11);
    chk("all_key_out", 32'(key_out), 32'h0);
    chk("all_press", 32'(press_pulse), 32'hF);
    idle(3);

    // reset while key 2 is qualifying
    drive(4'b1111);
    idle(15);
    drive(4'b1011);
    idle(4);
    @(negedge clk);
    #1 reset = 1'b1;
    idle(2);
    chk("rst_mid_key2", 32'(key_out[2]), 32'h1);
    @(negedge clk);
    #1 reset = 1'b0;
    latency("rst_settle_lat", 2, 1'b0, 11);
    idle(3);

    chk("press_cnt0", 32'(press_cnt[0]), 32'd2);
    chk("press_cnt1", 32'(press_cnt[1]), 32'd2);
    chk("press_cnt2", 32'(press_cnt[2]), 32'd2);
    chk("press_cnt3", 32'(press_cnt[3]), 32'd1);
    chk("rel_cnt0", 32'(rel_cnt[0]), 32'd2);
    chk("rel_cnt1", 32'(rel_cnt[1]), 32'd2);
    chk("rel_cnt2", 32'(rel_cnt[2]), 32'd1);
    chk("rel_cnt3", 32'(rel_cnt[3]), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
